// File: rtl/bus_arbiter_ctrl.sv
// Round-robin arbiter and bit-serial phase sequencer for the shared system bus.
// Moore outputs registered alongside the state; no input-to-output combinational path.
module bus_arbiter_ctrl #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 8,
   parameter int TIMEOUT     = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_MASTERS-1:0] m_req,
   input  logic                   slave_ack,
   output logic [NUM_MASTERS-1:0] m_grant,
   output logic                   addr_phase,
   output logic                   data_phase,
   output logic [3:0]             bit_idx,
   output logic                   bus_busy,
   output logic                   txn_done,
   output logic                   timeout_err
);

   localparam int         OW        = (NUM_MASTERS > 2) ? 2 : 1;
   localparam logic [3:0] ADDR_LAST = 4'(ADDR_WIDTH - 1);
   localparam logic [3:0] DATA_LAST = 4'(DATA_WIDTH - 1);
   localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_GRANT, S_ADDR, S_WAIT, S_DATA, S_DONE, S_ABORT
   } state_t;

   state_t          state;
   logic [OW-1:0]   owner;
   logic [OW-1:0]   last;
   logic [7:0]      to_cnt;
   logic [OW-1:0]   cand;
   logic [OW-1:0]   pick_idx;
   logic            pick_vld;

   // First requester strictly after 'last', scanning upward with wrap.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         cand = OW'((int'(last) + i) % NUM_MASTERS);
         if (m_req[cand] && !pick_vld) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   // bit_idx doubles as the bit counter during ADDR and DATA.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         owner       <= '0;
         last        <= OW'(NUM_MASTERS - 1);
         to_cnt      <= '0;
         m_grant     <= '0;
         addr_phase  <= 1'b0;
         data_phase  <= 1'b0;
         bit_idx     <= '0;
         bus_busy    <= 1'b0;
         txn_done    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_vld) begin
                  state    <= S_GRANT;
                  owner    <= pick_idx;
                  m_grant  <= NUM_MASTERS'(1) << pick_idx;
                  bus_busy <= 1'b1;
               end
            end
            S_GRANT: begin
               state      <= S_ADDR;
               addr_phase <= 1'b1;
               bit_idx    <= '0;
            end
            S_ADDR: begin
               if (bit_idx == ADDR_LAST) begin
                  state      <= S_WAIT;
                  to_cnt     <= '0;
                  addr_phase <= 1'b0;
                  bit_idx    <= '0;
               end else begin
                  bit_idx <= bit_idx + 4'd1;
               end
            end
            S_WAIT: begin
               // A late ack still wins over the timeout on the last allowed cycle.
               if (slave_ack) begin
                  state      <= S_DATA;
                  data_phase <= 1'b1;
                  bit_idx    <= '0;
               end else if (to_cnt == TO_LAST) begin
                  state       <= S_ABORT;
                  timeout_err <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
            end
            S_DATA: begin
               if (bit_idx == DATA_LAST) begin
                  state      <= S_DONE;
                  data_phase <= 1'b0;
                  bit_idx    <= '0;
                  txn_done   <= 1'b1;
               end else begin
                  bit_idx <= bit_idx + 4'd1;
               end
            end
            S_DONE, S_ABORT: begin
               state       <= S_IDLE;
               last        <= owner;
               m_grant     <= '0;
               bus_busy    <= 1'b0;
               txn_done    <= 1'b0;
               timeout_err <= 1'b0;
            end
            default: begin
               state       <= S_IDLE;
               m_grant     <= '0;
               addr_phase  <= 1'b0;
               data_phase  <= 1'b0;
               bit_idx     <= '0;
               bus_busy    <= 1'b0;
               txn_done    <= 1'b0;
               timeout_err <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Bench for bus_arbiter_ctrl: transaction-trajectory model checked every cycle plus directed pins.
module tb_bus_arbiter_ctrl;
   localparam int N  = 2;
   localparam int A  = 12;
   localparam int D  = 8;
   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] m_req = '0;
   logic         slave_ack = 1'b0;
   logic [N-1:0] m_grant;
   logic         addr_phase, data_phase, bus_busy, txn_done, timeout_err;
   logic [3:0]   bit_idx;

   int n_tests = 0;
   int n_fail  = 0;

   bus_arbiter_ctrl #(.NUM_MASTERS(N), .ADDR_WIDTH(A), .DATA_WIDTH(D), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .m_req(m_req), .slave_ack(slave_ack),
      .m_grant(m_grant), .addr_phase(addr_phase), .data_phase(data_phase),
      .bit_idx(bit_idx), .bus_busy(bus_busy), .txn_done(txn_done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Model: position t within the current transaction (t=0 is the grant cycle);
   // w is the number of ack-wait cycles, unknown (-1) until ack or timeout resolves it.
   bit m_busy = 1'b0;
   bit m_abort = 1'b0;
   int m_last = N - 1;
   int m_owner = 0;
   int m_t = 0;
   int m_w = -1;
   int waited;
   bit found;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy = 1'b0;
         m_last = N - 1;
      end else if (!m_busy) begin
         found = 1'b0;
         for (int i = 1; i <= N; i++) begin
            if (!found && m_req[(m_last + i) % N]) begin
               found   = 1'b1;
               m_owner = (m_last + i) % N;
            end
         end
         if (found) begin
            m_busy = 1'b1; m_t = 0; m_w = -1; m_abort = 1'b0;
         end
      end else if (m_w >= 0 && m_t == A + 1 + m_w + (m_abort ? 0 : D)) begin
         m_busy = 1'b0;
         m_last = m_owner;
      end else begin
         if (m_t > A && m_w < 0) begin
            waited = m_t - A;
            if (slave_ack) m_w = waited;
            else if (waited == TO) begin
               m_w = TO; m_abort = 1'b1;
            end
         end
         m_t++;
      end
   end

   function automatic logic [N+8:0] model_out();
      logic [N-1:0] g;
      logic a, d, bz, dn, er;
      logic [3:0] ix;
      int u;
      g = '0; a = 0; d = 0; bz = 0; dn = 0; er = 0; ix = '0;
      if (m_busy) begin
         g  = N'(1) << m_owner;
         bz = 1'b1;
         if (m_t >= 1 && m_t <= A) begin
            a = 1'b1; ix = 4'(m_t - 1);
         end else if (m_t > A && m_w >= 0 && m_t > A + m_w) begin
            if (m_abort) er = 1'b1;
            else begin
               u = m_t - (A + 1 + m_w);
               if (u < D) begin
                  d = 1'b1; ix = 4'(u);
               end else dn = 1'b1;
            end
         end
      end
      return {g, a, d, ix, bz, dn, er};
   endfunction

   wire [N+8:0] dut_out = {m_grant, addr_phase, data_phase, bit_idx, bus_busy, txn_done, timeout_err};

   always @(negedge clk) begin
      n_tests++;
      if (dut_out !== model_out()) begin
         n_fail++;
         $display("FAIL cycle_model t=%0t: got %b expected %b", $time, dut_out, model_out());
      end
   end

   task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_idle(input int lim);
      int k = 0;
      while (bus_busy && k < lim) begin
         @(negedge clk); k++;
      end
      pin("wait_idle", {31'd0, bus_busy}, 32'd0);
   endtask

   task automatic wait_busy(input int lim);
      int k = 0;
      while (!bus_busy && k < lim) begin
         @(negedge clk); k++;
      end
      pin("wait_busy", {31'd0, bus_busy}, 32'd1);
   endtask

   initial begin
      logic [N-1:0] gl [3];
      int ng, gap, nwait;
      bit prev_busy, seen_addr, tflag, dflag, ack_set;

      // Reset held while requests toggle
      #1 reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); m_req = N'($urandom);
      end
      pin("rst_outputs", {{(32-N-9){1'b0}}, dut_out}, 32'd0);
      m_req = '0;
      @(negedge clk); reset = 1'b1;
      repeat (3) @(negedge clk);
      pin("post_rst_idle", {{(32-N-9){1'b0}}, dut_out}, 32'd0);

      // Single master with cycle-numbered pins
      m_req = 2'b01; slave_ack = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (k == 2) m_req = '0;
         if (k == 1)  pin("s_grant_c1", {30'd0, m_grant}, 32'd1);
         if (k == 1)  pin("s_noaddr_c1", {31'd0, addr_phase}, 32'd0);
         if (k == 2)  pin("s_addr_c2", {27'd0, addr_phase, bit_idx}, 32'h10);
         if (k == 13) pin("s_addr_c13", {27'd0, addr_phase, bit_idx}, 32'h1b);
         if (k == 14) pin("s_wait_c14", {29'd0, addr_phase, data_phase, bus_busy}, 32'd1);
         if (k == 15) pin("s_data_c15", {27'd0, data_phase, bit_idx}, 32'h10);
         if (k == 22) pin("s_data_c22", {27'd0, data_phase, bit_idx}, 32'h17);
         if (k == 23) pin("s_done_c23", {29'd0, txn_done, m_grant}, 32'd5);
         if (k == 24) pin("s_idle_c24", {29'd0, bus_busy, m_grant}, 32'd0);
      end

      // Round robin with both requesting
      m_req = 2'b11; ng = 0; gap = 0; prev_busy = 1'b0;
      for (int k = 0; k < 200 && ng < 3; k++) begin
         @(negedge clk);
         if (bus_busy && !prev_busy) begin
            gl[ng] = m_grant;
            if (ng > 0) pin("rr_gap", gap, 32'd1);
            ng++; gap = 0;
         end
         if (!bus_busy) gap++;
         prev_busy = bus_busy;
      end
      pin("rr_count", ng, 32'd3);
      pin("rr_g0", {30'd0, gl[0]}, 32'd2);
      pin("rr_g1", {30'd0, gl[1]}, 32'd1);
      pin("rr_g2", {30'd0, gl[2]}, 32'd2);
      m_req = '0;
      wait_idle(60);

      // Timeout
      @(negedge clk);
      m_req = 2'b01; slave_ack = 1'b0;
      nwait = 0; seen_addr = 0; tflag = 0; dflag = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (bus_busy) m_req = '0;
         if (addr_phase) seen_addr = 1;
         if (seen_addr && bus_busy && !addr_phase && !data_phase && !timeout_err && !txn_done) nwait++;
         if (timeout_err) tflag = 1;
         if (txn_done) dflag = 1;
         if (tflag && !bus_busy) break;
      end
      pin("to_wait_cycles", nwait, TO);
      pin("to_err_seen", {31'd0, tflag}, 32'd1);
      pin("to_no_done", {31'd0, dflag}, 32'd0);
      m_req = 2'b11; slave_ack = 1'b1;
      wait_busy(10);
      pin("to_next_m1", {30'd0, m_grant}, 32'd2);
      m_req = '0;
      wait_idle(60);

      // Ack on the final allowed wait cycle
      @(negedge clk);
      m_req = 2'b01; slave_ack = 1'b0;
      nwait = 0; seen_addr = 0; tflag = 0; dflag = 0; ack_set = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (bus_busy) m_req = '0;
         if (ack_set) begin
            pin("late_ack_data", {31'd0, data_phase}, 32'd1);
            ack_set = 0;
         end
         if (addr_phase) seen_addr = 1;
         if (seen_addr && bus_busy && !addr_phase && !data_phase && !timeout_err && !txn_done) begin
            nwait++;
            if (nwait == TO) begin
               slave_ack = 1'b1; ack_set = 1;
            end
         end
         if (timeout_err) tflag = 1;
         if (txn_done) dflag = 1;
         if ((tflag || dflag) && !bus_busy) break;
      end
      pin("late_ack_no_err", {31'd0, tflag}, 32'd0);
      pin("late_ack_done", {31'd0, dflag}, 32'd1);

      // Drop request during address bit 5
      @(negedge clk);
      m_req = 2'b10; slave_ack = 1'b1; dflag = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (addr_phase && bit_idx == 4'd5) m_req = '0;
         if (txn_done) dflag = 1;
         if (dflag && !bus_busy) break;
      end
      pin("drop_req_done", {31'd0, dflag}, 32'd1);

      // Reset during data bit 3
      @(negedge clk);
      m_req = 2'b01; slave_ack = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bus_busy) m_req = '0;
         if (data_phase && bit_idx == 4'd3) break;
      end
      pin("pre_rst_data3", {27'd0, data_phase, bit_idx}, 32'h13);
      #2 reset = 1'b0;
      #1 pin("mid_rst_zero", {{(32-N-9){1'b0}}, dut_out}, 32'd0);
      m_req = 2'b10;
      repeat (3) @(negedge clk);
      reset = 1'b1; m_req = 2'b11;
      wait_busy(10);
      pin("post_rst_m0", {30'd0, m_grant}, 32'd1);
      m_req = '0;
      wait_idle(60);

      // Randomised traffic checked by the model
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) m_req = N'($urandom);
         if ((k / 300) % 2 == 0) slave_ack = ($urandom_range(0, 3) == 0);
         else                    slave_ack = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 599) == 0) begin
            #2 reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
